backward_maccum_seq: RTL

//  Time-multiplexed backward-pass matrix-vector multiply-accumulate: Accum2[c] = sum_k W[c][k]*Delta0[k].

---
 rtl/backward_maccum_pkg.sv | 19 +
 rtl/maccum_lane.sv | 35 +++
 rtl/backward_maccum_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/backward_maccum_pkg.sv
// Shared types and elaboration helpers for the sequential backward multiply-accumulate.
package backward_maccum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int clogW(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int ceilDiv(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/maccum_lane.sv
// One signed WV x WV product, scaled back to WV fixed-point format and wrapped to WV bits.
// Rounding (half up) is enabled by defining BACKWARD_MACCUM_ROUND_EN; otherwise the shift floors.
module maccum_lane #(
    parameter int WV   = 5,
    parameter int FRAC = 2
) (
    input  logic signed [WV-1:0] w,
    input  logic signed [WV-1:0] d,
    output logic signed [WV-1:0] p
);
    localparam int PW = 2 * WV;

    logic signed [PW-1:0] wExt, dExt, prod, biased, scaled;

    assign wExt = PW'(w);
    assign dExt = PW'(d);
    assign prod = wExt * dExt;

`ifdef BACKWARD_MACCUM_ROUND_EN
    generate
        if (FRAC > 0) begin : gRnd
            assign biased = prod + (PW'(1) <<< (FRAC - 1));
        end else begin : gNoRnd
            assign biased = prod;
        end
    endgenerate
`else
    assign biased = prod;
`endif

    // The largest product magnitude leaves headroom for the bias, so nothing wraps before the shift.
    assign scaled = biased >>> FRAC;
    assign p      = WV'(scaled);

endmodule

// File: rtl/backward_maccum_seq.sv
// Time-multiplexed backward matrix-vector MAC: A[c] = sum_k W[c][k]*D[k], NL columns per cycle.
// Build option BACKWARD_MACCUM_ROUND_EN selects round-half-up product scaling inside maccum_lane.
module backward_maccum_seq
    import backward_maccum_pkg::*;
#(
    parameter  int NN   = 7,
    parameter  int NC   = 11,
    parameter  int WV   = 5,
    parameter  int FRAC = 2,
    parameter  int NL   = 1,
    localparam int WA   = WV + $clog2(NN)
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iValid_AM_Weight,
    output logic                  oReady_AM_Weight,
    input  logic [NC*NN*WV-1:0]   iData_AM_Weight,
    input  logic                  iValid_AM_Delta0,
    output logic                  oReady_AM_Delta0,
    input  logic [NN*WV-1:0]      iData_AM_Delta0,
    output logic                  oValid_BM_Accum2,
    input  logic                  iReady_BM_Accum2,
    output logic [NC*WA-1:0]      oData_BM_Accum2
);
    localparam int S   = ceilDiv(NN, NL);
    localparam int SW  = clogW(S);
    localparam int KW  = clogW(NN + NL);
    localparam int KIW = clogW(NN);

    generate
        if (NL < 1 || NL > NN) begin : gBadNl
            $error("backward_maccum_seq: NL must be within 1..NN");
        end
    endgenerate

    state_t              state;
    logic [SW-1:0]       step;
    logic [KW-1:0]       base;
    logic signed [WV-1:0] wMat [NC][NN];
    logic signed [WV-1:0] dVec [NN];
    logic signed [WA-1:0] acc     [NC];
    logic signed [WA-1:0] laneSum [NC];
    logic signed [WA-1:0] nextAcc [NC];
    logic signed [WV-1:0] laneD [NL];
    logic signed [WV-1:0] laneW [NC][NL];
    logic signed [WV-1:0] laneP [NC][NL];
    logic [NL-1:0]       laneOn;
    logic                accept, lastStep, slotFree;

    assign accept           = (state == IDLE) && iValid_AM_Weight && iValid_AM_Delta0;
    assign oReady_AM_Weight = (state == IDLE) && iValid_AM_Delta0;
    assign oReady_AM_Delta0 = (state == IDLE) && iValid_AM_Weight;
    assign lastStep         = (step == SW'(S - 1));
    assign slotFree         = !oValid_BM_Accum2 || iReady_BM_Accum2;
    assign base             = KW'(step) * KW'(NL);

    // Column k = step*NL + l; lanes past the last column are masked out of the sum.
    generate
        for (genvar l = 0; l < NL; l++) begin : gLane
            logic [KW-1:0]  kIdx;
            logic [KIW-1:0] kSel;
            assign kIdx      = base + KW'(l);
            assign laneOn[l] = (kIdx < KW'(NN));
            assign kSel      = laneOn[l] ? KIW'(kIdx) : '0;
            assign laneD[l]  = dVec[kSel];
            for (genvar c = 0; c < NC; c++) begin : gRow
                assign laneW[c][l] = wMat[c][kSel];
                maccum_lane #(.WV(WV), .FRAC(FRAC)) uLane (
                    .w (laneW[c][l]),
                    .d (laneD[l]),
                    .p (laneP[c][l])
                );
            end
        end
    endgenerate

    always_comb begin
        for (int c = 0; c < NC; c++) begin
            laneSum[c] = '0;
            for (int l = 0; l < NL; l++) begin
                if (laneOn[l]) laneSum[c] = laneSum[c] + WA'(laneP[c][l]);
            end
            nextAcc[c] = acc[c] + laneSum[c];
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state            <= IDLE;
            step             <= '0;
            oValid_BM_Accum2 <= 1'b0;
            oData_BM_Accum2  <= '0;
            for (int c = 0; c < NC; c++) begin
                acc[c] <= '0;
                for (int k = 0; k < NN; k++) wMat[c][k] <= '0;
            end
            for (int k = 0; k < NN; k++) dVec[k] <= '0;
        end else begin
            // A refill below in the same cycle overrides this drain.
            if (oValid_BM_Accum2 && iReady_BM_Accum2) oValid_BM_Accum2 <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int c = 0; c < NC; c++) begin
                            acc[c] <= '0;
                            for (int k = 0; k < NN; k++)
                                wMat[c][k] <= iData_AM_Weight[(c*NN+k)*WV +: WV];
                        end
                        for (int k = 0; k < NN; k++) dVec[k] <= iData_AM_Delta0[k*WV +: WV];
                        step  <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int c = 0; c < NC; c++) acc[c] <= nextAcc[c];
                    if (lastStep) begin
                        step <= '0;
                        if (slotFree) begin
                            for (int c = 0; c < NC; c++) oData_BM_Accum2[c*WA +: WA] <= nextAcc[c];
                            oValid_BM_Accum2 <= 1'b1;
                            state            <= IDLE;
                        end else begin
                            state <= HOLD;
                        end
                    end else begin
                        step <= step + SW'(1);
                    end
                end
                HOLD: begin
                    if (slotFree) begin
                        for (int c = 0; c < NC; c++) oData_BM_Accum2[c*WA +: WA] <= acc[c];
                        oValid_BM_Accum2 <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
